// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - LFSR-driven built-in self-test engine for a WIDTH-bit ripple-carry adder
module adder_bist #(
  parameter int          WIDTH  = 4,
  parameter int          PATNUM = 1000,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               carry,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        pat_cnt,
  output logic [15:0]        err_cnt,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] PAT_LAST = 16'(PATNUM - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t         state, state_nxt;
  logic [15:0]    lfsr;
  logic [15:0]    lfsr_nxt;
  logic [WIDTH:0] golden;
  logic           mismatch;

  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  // Case inequality so an undriven or X adder output is reported, not masked
  assign mismatch = ({carry, sum} !== golden);

  assign busy = (state == DRIVE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      state_nxt = CHECK;
      CHECK:      state_nxt = (pat_cnt == PAT_LAST) ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= SEED_EFF;
      a        <= '0;
      b        <= '0;
      cin      <= 1'b0;
      golden   <= '0;
      pat_cnt  <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr     <= SEED_EFF;
            pat_cnt  <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
          end
        end
        DRIVE: begin
          a      <= lfsr[WIDTH-1:0];
          b      <= lfsr[2*WIDTH-1:WIDTH];
          cin    <= lfsr[15];
          golden <= {1'b0, lfsr[WIDTH-1:0]} + {1'b0, lfsr[2*WIDTH-1:WIDTH]}
                    + {{WIDTH{1'b0}}, lfsr[15]};
        end
        CHECK: begin
          pat_cnt <= pat_cnt + 16'd1;
          lfsr    <= lfsr_nxt;
          if (mismatch) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            // err_cnt saturates rather than wraps, so zero means no earlier failure
            if (err_cnt == 16'h0000) fail_vec <= {a, b, cin};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// tb/tb_adder_bist.sv - directed self-checking bench for adder_bist
module tb_adder_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic       force_c0 = 1'b0, force_c1 = 1'b0;
  logic [3:0] a0, b0, a1, b1, sum0, sum1;
  logic       cin0, cin1, carry0, carry1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] pat0, err0, pat1, err1;
  logic [8:0]  fv0, fv1;
  logic [4:0]  s0, s1;

  // Reference adders feeding the two engines, with an optional stuck-at-0 carry
  assign s0     = {1'b0, a0} + {1'b0, b0} + {4'b0, cin0};
  assign sum0   = s0[3:0];
  assign carry0 = force_c0 ? 1'b0 : s0[4];
  assign s1     = {1'b0, a1} + {1'b0, b1} + {4'b0, cin1};
  assign sum1   = s1[3:0];
  assign carry1 = force_c1 ? 1'b0 : s1[4];

  adder_bist #(.WIDTH(4), .PATNUM(1000), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .sum(sum0), .carry(carry0), .busy(busy0), .done(done0), .pass(pass0),
    .pat_cnt(pat0), .err_cnt(err0), .fail_vec(fv0));

  adder_bist #(.WIDTH(4), .PATNUM(1), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .carry(carry1), .busy(busy1), .done(done1), .pass(pass1),
    .pat_cnt(pat1), .err_cnt(err1), .fail_vec(fv1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l = 16'hACE1;
    for (int i = 0; i < n; i++) l = lfsr_step(l);
    return l;
  endfunction

  function automatic int carries(input int n);
    logic [15:0] l = 16'hACE1;
    logic [4:0]  t;
    int          c = 0;
    for (int i = 0; i < n; i++) begin
      t = {1'b0, l[3:0]} + {1'b0, l[7:4]} + {4'b0, l[15]};
      if (t[4]) c++;
      l = lfsr_step(l);
    end
    return c;
  endfunction

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int n0, output int n);
    n = n0;
    while (n < 6000) begin
      @(posedge clk);
      n++;
      #1;
      if (which ? done1 : done0) break;
    end
  endtask

  logic [15:0] last_l;
  int n;

  initial begin
    last_l = lfsr_at(999);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy0}, 0);
    chk("rst_done", {31'b0, done0}, 0);
    chk("rst_pass", {31'b0, pass0}, 0);
    chk("rst_pat", {16'b0, pat0}, 0);
    chk("rst_err", {16'b0, err0}, 0);
    chk("rst_fv", {23'b0, fv0}, 0);
    chk("rst_abc", {23'b0, a0, b0, cin0}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Clean run, first-vector mapping and exact latency
    pulse(0);
    chk("run1_busy", {31'b0, busy0}, 1);
    @(posedge clk); #1;
    chk("vec1_a", {28'b0, a0}, 32'h1);
    chk("vec1_b", {28'b0, b0}, 32'hE);
    chk("vec1_cin", {31'b0, cin0}, 1);
    wait_done(0, 1, n);
    chk("run1_latency", n, 2000);
    chk("run1_pat", {16'b0, pat0}, 1000);
    chk("run1_err", {16'b0, err0}, 0);
    chk("run1_pass", {31'b0, pass0}, 1);
    chk("run1_fv", {23'b0, fv0}, 0);
    repeat (5) @(posedge clk); #1;
    chk("hold_done", {31'b0, done0}, 1);
    chk("hold_pat", {16'b0, pat0}, 1000);
    chk("hold_abc", {23'b0, a0, b0, cin0}, {23'b0, last_l[3:0], last_l[7:4], last_l[15]});

    // Carry stuck at 0, restarted directly from DONE
    force_c0 = 1'b1;
    pulse(0);
    chk("run2_clr_pat", {16'b0, pat0}, 0);
    chk("run2_clr_err", {16'b0, err0}, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("run2_first_err", {16'b0, err0}, 1);
    chk("run2_first_fv", {23'b0, fv0}, 32'h03D);
    wait_done(0, 2, n);
    chk("run2_latency", n, 2000);
    chk("run2_err", {16'b0, err0}, carries(1000));
    chk("run2_fv", {23'b0, fv0}, 32'h03D);
    chk("run2_pass", {31'b0, pass0}, 0);
    force_c0 = 1'b0;

    // start while busy must be ignored
    pulse(0);
    n = 0;
    while (n < 6000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1000) begin
        chk("run3_mid_pat", {16'b0, pat0}, 500);
        start0 = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      if (done0) break;
    end
    chk("run3_latency", n, 2000);
    chk("run3_pat", {16'b0, pat0}, 1000);
    chk("run3_pass", {31'b0, pass0}, 1);

    // Asynchronous reset mid-run, then a fresh full run
    force_c0 = 1'b1;
    pulse(0);
    repeat (600) @(posedge clk);
    #1;
    chk("run4_pre_pat", {16'b0, pat0}, 300);
    #2 rst_n = 1'b0;
    #1;
    chk("run4_rst_busy", {31'b0, busy0}, 0);
    chk("run4_rst_pat", {16'b0, pat0}, 0);
    chk("run4_rst_err", {16'b0, err0}, 0);
    chk("run4_rst_fv", {23'b0, fv0}, 0);
    chk("run4_rst_abc", {23'b0, a0, b0, cin0}, 0);
    force_c0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    pulse(0);
    wait_done(0, 0, n);
    chk("run5_latency", n, 2000);
    chk("run5_pat", {16'b0, pat0}, 1000);
    chk("run5_err", {16'b0, err0}, 0);
    chk("run5_pass", {31'b0, pass0}, 1);

    // Single-pattern engine
    pulse(1);
    wait_done(1, 0, n);
    chk("p1_latency", n, 2);
    chk("p1_pat", {16'b0, pat1}, 1);
    chk("p1_pass", {31'b0, pass1}, 1);
    force_c1 = 1'b1;
    pulse(1);
    chk("p1_restart_done", {31'b0, done1}, 0);
    wait_done(1, 0, n);
    chk("p1_bad_latency", n, 2);
    chk("p1_bad_err", {16'b0, err1}, 1);
    chk("p1_bad_fv", {23'b0, fv1}, 32'h03D);
    chk("p1_bad_pass", {31'b0, pass1}, 0);
    force_c1 = 1'b0;
    pulse(1);
    wait_done(1, 0, n);
    chk("p1_clean_err", {16'b0, err1}, 0);
    chk("p1_clean_fv", {23'b0, fv1}, 0);
    chk("p1_clean_pass", {31'b0, pass1}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
